add_sub_pipe: RTL

Parametrised, pipelined two's-complement adder/subtractor with optional signed saturation and status flags. Carry ripples one CHUNK-bit slice per pipeline stage, so the clock rate does not depend on WIDTH. It sits in the datapath ahead of ALU result muxing. A valid/ready handshake on both sides supports backpressure.

---
 rtl/add_sub_pipe.sv | 122 ++++++++++++
 1 files changed

// File: rtl/add_sub_pipe.sv
// Pipelined add/sub with optional signed saturation; one CHUNK-bit carry slice per stage, latency STAGES.
// Whole pipe advances only when in_ready; a full last stage stalls everything until out_ready.
module add_sub_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero,
  output logic             Neg
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int MSB    = WIDTH - 1;

  // Per-stage registers: operands ride along whole, r_q accumulates finished slices.
  logic             v_q   [STAGES];
  logic             c_q   [STAGES];
  logic             sat_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] r_q   [STAGES];
  logic             loaded_q;

  logic             v_in   [STAGES];
  logic             c_in   [STAGES];
  logic             sat_in [STAGES];
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] r_in   [STAGES];
  logic [WIDTH-1:0] r_nxt  [STAGES];
  logic [CHUNK:0]   sl     [STAGES];

  logic             adv;
  logic             ovf;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] raw;

  assign in_ready = !v_q[STAGES-1] || out_ready;
  assign adv      = in_ready;

  always_comb begin
    v_in[0]   = in_valid;
    a_in[0]   = A;
    b_in[0]   = Sub ? ~B : B;
    c_in[0]   = Sub;
    sat_in[0] = Sat;
    r_in[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k]   = v_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      c_in[k]   = c_q[k-1];
      sat_in[k] = sat_q[k-1];
      r_in[k]   = r_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sl[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
            + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, c_in[k]};
      r_nxt[k] = r_in[k];
      r_nxt[k][k*CHUNK +: CHUNK] = sl[k][CHUNK-1:0];
    end
  end

  // Data registers load only with valid beats so idle outputs keep their reset zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        sat_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
      end
    end else if (adv) begin
      if (v_in[STAGES-1]) loaded_q <= 1'b1;
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        if (v_in[k]) begin
          c_q[k]   <= sl[k][CHUNK];
          sat_q[k] <= sat_in[k];
          a_q[k]   <= a_in[k];
          b_q[k]   <= b_in[k];
          r_q[k]   <= r_nxt[k];
        end
      end
    end
  end

  assign raw   = r_q[STAGES-1];
  assign a_msb = a_q[STAGES-1][MSB];
  assign b_msb = b_q[STAGES-1][MSB];
  assign ovf   = (a_msb == b_msb) && (raw[MSB] != a_msb);

  always_comb begin
    Sum = raw;
    if (sat_q[STAGES-1] && ovf)
      Sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  assign out_valid = v_q[STAGES-1];
  assign Carry     = c_q[STAGES-1];
  assign Overflow  = ovf;
  assign Neg       = Sum[MSB];
  assign Zero      = loaded_q && (Sum == '0);

endmodule
